trap_sequencer: RTL and testbench

- Machine-mode trap controller for the RV32I pipeline.
- Prioritises synchronous exceptions from EX and pending machine interrupts, kills the EX instruction and sequences pipeline flush.
- Writes mepc/mcause/mtval through the single CSR write port, then redirects fetch to mtvec.
- Also sequences mret: flush, restore MIE, redirect to mepc.

---
 rtl/trap_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_trap_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap/mret sequencer: accept, flush, write mepc/mcause/mtval, redirect
module trap_sequencer #(
  parameter int          FLUSH_CYCLES = 3,
  parameter logic [11:0] CSR_MEPC     = 12'h341,
  parameter logic [11:0] CSR_MCAUSE   = 12'h342,
  parameter logic [11:0] CSR_MTVAL    = 12'h343
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        illegal_ops_ex,
  input  logic        ebreak_ex,
  input  logic        ecall_ex,
  input  logic        mret_ex,
  input  logic [31:0] pc_ex,
  input  logic [31:0] inst_ex,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  input  logic        csr_mstatus_mie,
  input  logic        csr_meie,
  input  logic        csr_mtie,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        g_exception,
  output logic        pipe_flush,
  output logic        trap_busy,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        mie_clear,
  output logic        mie_restore,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_W_EPC, S_W_CAUSE, S_W_TVAL, S_REDIR
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mret_q, mret_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] target_q, target_d;

  logic        eirq, tirq, is_trap, accept, take_trap, take_mret;
  logic        ev_intr;
  logic [31:0] ev_cause, ev_tval, ev_target, vec_base;

  assign eirq      = ext_irq & csr_meie & csr_mstatus_mie;
  assign tirq      = tmr_irq & csr_mtie & csr_mstatus_mie;
  assign is_trap   = eirq | tirq | illegal_ops_ex | ebreak_ex | ecall_ex;
  assign accept    = (state_q == S_IDLE) & ~stall & ~rst;
  assign take_trap = accept & is_trap;
  assign take_mret = accept & ~is_trap & mret_ex;
  assign g_exception = take_trap;

  // Fixed priority chain: interrupts first, then EX exceptions
  always_comb begin
    ev_intr  = 1'b0;
    ev_cause = 32'd0;
    ev_tval  = 32'd0;
    if (eirq) begin
      ev_intr  = 1'b1;
      ev_cause = 32'h8000_000B;
    end else if (tirq) begin
      ev_intr  = 1'b1;
      ev_cause = 32'h8000_0007;
    end else if (illegal_ops_ex) begin
      ev_cause = 32'd2;
      ev_tval  = inst_ex;
    end else if (ebreak_ex) begin
      ev_cause = 32'd3;
      ev_tval  = pc_ex;
    end else if (ecall_ex) begin
      ev_cause = 32'd11;
    end
  end

  assign vec_base  = {csr_mtvec[31:2], 2'b00};
  assign ev_target = (ev_intr && csr_mtvec[1:0] == 2'b01)
                   ? vec_base + {25'd0, ev_cause[4:0], 2'b00} : vec_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      mret_q   <= 1'b0;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
      tval_q   <= 32'd0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mret_q   <= mret_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mret_d   = mret_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (take_trap || take_mret) begin
          state_d  = S_FLUSH;
          cnt_d    = 4'd0;
          mret_d   = take_mret;
          cause_d  = ev_cause;
          epc_d    = pc_ex;
          tval_d   = ev_tval;
          target_d = take_mret ? csr_mepc : ev_target;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) state_d = mret_q ? S_REDIR : S_W_EPC;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      S_W_EPC:   state_d = S_W_CAUSE;
      S_W_CAUSE: state_d = S_W_TVAL;
      S_W_TVAL:  state_d = S_REDIR;
      S_REDIR:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_flush  = 1'b0;
    trap_busy   = (state_q != S_IDLE);
    csr_we      = 1'b0;
    csr_waddr   = 12'd0;
    csr_wdata   = 32'd0;
    mie_clear   = 1'b0;
    mie_restore = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;
    case (state_q)
      S_FLUSH: begin
        pipe_flush  = 1'b1;
        mie_clear   = (cnt_q == 4'd0) & ~mret_q;
        mie_restore = (cnt_q == 4'd0) &  mret_q;
      end
      S_W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = epc_q;
      end
      S_W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
      end
      S_W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = tval_q;
      end
      S_REDIR: begin
        pipe_flush  = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - randomized and directed bench for trap_sequencer against a timeline model
module tb_trap_sequencer;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic rst, stall, illegal_ops_ex, ebreak_ex, ecall_ex, mret_ex;
  logic [31:0] pc_ex, inst_ex, csr_mtvec, csr_mepc;
  logic ext_irq, tmr_irq, csr_mstatus_mie, csr_meie, csr_mtie;
  logic g_exception, pipe_flush, trap_busy, csr_we, mie_clear, mie_restore, pc_redirect;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, pc_target;

  always #5 clk = ~clk;

  trap_sequencer #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .illegal_ops_ex(illegal_ops_ex), .ebreak_ex(ebreak_ex), .ecall_ex(ecall_ex), .mret_ex(mret_ex),
    .pc_ex(pc_ex), .inst_ex(inst_ex), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .csr_mstatus_mie(csr_mstatus_mie), .csr_meie(csr_meie), .csr_mtie(csr_mtie),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .g_exception(g_exception), .pipe_flush(pipe_flush), .trap_busy(trap_busy),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .mie_clear(mie_clear), .mie_restore(mie_restore),
    .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  typedef struct packed {
    logic        gexc;
    logic        flush;
    logic        busy;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        clr;
    logic        rest;
    logic        redir;
    logic [31:0] tgt;
  } obs_t;

  obs_t sched[$];
  int checks = 0;
  int passed = 0;

  logic [11:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [31:0] redir_log[$];
  int gexc_cnt, busy_cnt, clr_cnt, rest_cnt;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] wdata_at(int i);
    return (i < wlog_data.size()) ? wlog_data[i] : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] waddr_at(int i);
    return (i < wlog_addr.size()) ? {20'd0, wlog_addr[i]} : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] redir_at(int i);
    return (i < redir_log.size()) ? redir_log[i] : 32'hBAD0_BAD0;
  endfunction

  // Model: on acceptance, push the whole future output timeline as a list of per-cycle records
  always @(negedge clk) begin
    obs_t exp, act, e;
    logic eirq, tirq, intr, trap;
    logic [31:0] cause, tval, base, tgt;
    exp = sched.size() > 0 ? sched[0] : '0;
    eirq = ext_irq & csr_meie & csr_mstatus_mie;
    tirq = tmr_irq & csr_mtie & csr_mstatus_mie;
    trap = eirq | tirq | illegal_ops_ex | ebreak_ex | ecall_ex;
    exp.gexc = (sched.size() == 0) && !rst && !stall && trap;

    act = '0;
    act.gexc = g_exception; act.flush = pipe_flush; act.busy = trap_busy;
    act.we = csr_we; act.waddr = csr_waddr; act.wdata = csr_wdata;
    act.clr = mie_clear; act.rest = mie_restore; act.redir = pc_redirect; act.tgt = pc_target;
    checks++;
    if (act === exp) passed++;
    else $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, act, exp);

    if (csr_we) begin wlog_addr.push_back(csr_waddr); wlog_data.push_back(csr_wdata); end
    if (pc_redirect) redir_log.push_back(pc_target);
    if (g_exception) gexc_cnt++;
    if (trap_busy) busy_cnt++;
    if (mie_clear) clr_cnt++;
    if (mie_restore) rest_cnt++;

    if (rst) sched.delete();
    else if (sched.size() > 0) void'(sched.pop_front());
    else if (!stall && (trap || mret_ex)) begin
      intr = eirq | tirq;
      cause = eirq ? 32'h8000_000B : tirq ? 32'h8000_0007 : illegal_ops_ex ? 32'd2 :
              ebreak_ex ? 32'd3 : 32'd11;
      tval = (!intr && illegal_ops_ex) ? inst_ex : (!intr && ebreak_ex) ? pc_ex : 32'd0;
      base = csr_mtvec & 32'hFFFF_FFFC;
      tgt = (intr && csr_mtvec[1:0] == 2'b01) ? base + 4 * (cause % 32) : base;
      for (int i = 0; i < FC; i++) begin
        e = '0; e.flush = 1; e.busy = 1;
        if (trap) e.clr = (i == 0); else e.rest = (i == 0);
        sched.push_back(e);
      end
      if (trap) begin
        e = '0; e.busy = 1; e.we = 1;
        e.waddr = 12'h341; e.wdata = pc_ex; sched.push_back(e);
        e.waddr = 12'h342; e.wdata = cause; sched.push_back(e);
        e.waddr = 12'h343; e.wdata = tval;  sched.push_back(e);
      end
      e = '0; e.flush = 1; e.busy = 1; e.redir = 1;
      e.tgt = trap ? tgt : csr_mepc;
      sched.push_back(e);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); redir_log.delete();
    gexc_cnt = 0; busy_cnt = 0; clr_cnt = 0; rest_cnt = 0;
  endtask

  task automatic quiet();
    stall = 0; illegal_ops_ex = 0; ebreak_ex = 0; ecall_ex = 0; mret_ex = 0;
    ext_irq = 0; tmr_irq = 0;
  endtask

  initial begin
    rst = 1; quiet();
    pc_ex = 0; inst_ex = 0; csr_mtvec = 32'h200; csr_mepc = 0;
    csr_mstatus_mie = 0; csr_meie = 0; csr_mtie = 0;
    clear_logs();
    step(2);
    rst = 0;
    check("reset_busy", {31'd0, trap_busy}, 32'd0);
    check("reset_flush", {31'd0, pipe_flush}, 32'd0);

    // Illegal instruction
    clear_logs();
    pc_ex = 32'h100; inst_ex = 32'hFFFF_FFFF; csr_mtvec = 32'h200; illegal_ops_ex = 1;
    step(1); illegal_ops_ex = 0;
    step(10);
    check("ill_nwrites", wlog_addr.size(), 3);
    check("ill_epc_addr", waddr_at(0), 32'h341);
    check("ill_epc", wdata_at(0), 32'h100);
    check("ill_cause", wdata_at(1), 32'd2);
    check("ill_tval", wdata_at(2), 32'hFFFF_FFFF);
    check("ill_target", redir_at(0), 32'h200);
    check("ill_busy_cycles", busy_cnt, 7);
    check("ill_mie_clear", clr_cnt, 1);

    // External interrupt beats ecall, vectored
    clear_logs();
    csr_mtvec = 32'h201; csr_mstatus_mie = 1; csr_meie = 1;
    ext_irq = 1; ecall_ex = 1; pc_ex = 32'h180;
    step(1); ext_irq = 0; ecall_ex = 0;
    step(10);
    check("eirq_gexc", gexc_cnt, 1);
    check("eirq_cause", wdata_at(1), 32'h8000_000B);
    check("eirq_tval", wdata_at(2), 32'd0);
    check("eirq_target", redir_at(0), 32'h22C);

    // Timer masked by MIE, then taken
    clear_logs();
    csr_mtvec = 32'h200; csr_mstatus_mie = 0; csr_mtie = 1; tmr_irq = 1;
    step(5);
    check("tirq_masked", gexc_cnt + busy_cnt, 0);
    csr_mstatus_mie = 1;
    step(1); tmr_irq = 0;
    step(10);
    check("tirq_cause", wdata_at(1), 32'h8000_0007);
    check("tirq_target", redir_at(0), 32'h200);

    // mret
    clear_logs();
    csr_mepc = 32'h400; mret_ex = 1;
    step(1); mret_ex = 0; csr_mepc = 32'h999;
    step(8);
    check("mret_gexc", gexc_cnt, 0);
    check("mret_restore", rest_cnt, 1);
    check("mret_nwrites", wlog_addr.size(), 0);
    check("mret_target", redir_at(0), 32'h400);
    check("mret_busy", busy_cnt, 4);

    // ebreak held off by stall
    clear_logs();
    pc_ex = 32'h300; ebreak_ex = 1; stall = 1;
    step(2);
    check("ebrk_stalled", gexc_cnt + busy_cnt, 0);
    stall = 0;
    step(1); ebreak_ex = 0;
    step(10);
    check("ebrk_gexc", gexc_cnt, 1);
    check("ebrk_tval", wdata_at(2), 32'h300);

    // Reset during W_CAUSE
    clear_logs();
    pc_ex = 32'h500; illegal_ops_ex = 1;
    step(1); illegal_ops_ex = 0;
    step(4);
    rst = 1;
    step(1); rst = 0;
    step(4);
    check("rst_nwrites", wlog_addr.size(), 2);
    check("rst_no_redir", redir_log.size(), 0);
    clear_logs();
    pc_ex = 32'h600; ecall_ex = 1;
    step(1); ecall_ex = 0;
    step(10);
    check("post_rst_cause", wdata_at(1), 32'd11);
    check("post_rst_epc", wdata_at(0), 32'h600);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      stall = ($urandom_range(0, 3) == 0);
      illegal_ops_ex = ($urandom_range(0, 9) == 0);
      ebreak_ex = ($urandom_range(0, 9) == 0);
      ecall_ex = ($urandom_range(0, 9) == 0);
      mret_ex = ($urandom_range(0, 6) == 0);
      ext_irq = ($urandom_range(0, 11) == 0);
      tmr_irq = ($urandom_range(0, 11) == 0);
      csr_mstatus_mie = $urandom_range(0, 1);
      csr_meie = $urandom_range(0, 1);
      csr_mtie = $urandom_range(0, 1);
      pc_ex = $urandom; inst_ex = $urandom; csr_mtvec = $urandom; csr_mepc = $urandom;
      step(1);
    end
    rst = 0; quiet();
    step(20);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
